// File: rtl/bmac.sv
// bmac: signed 4-bit dot-product multiply-accumulate leaf.
// Eight (IN_WIDTH/4) lane products come from a constant product table.
// They are registered, then summed through a balanced adder tree and registered again.
// Optional feature macro: BMAC_ACCUM_EN adds a saturating running-sum accumulator with clear.
module bmac #(
   parameter int IN_WIDTH     = 32,
   parameter int LUT_WIDTH    = 8,
   parameter int OUTPUT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic                    acc_clr,
   input  logic [IN_WIDTH-1:0]     bmac_in_0,
   input  logic [IN_WIDTH-1:0]     bmac_in_1,
   output logic [OUTPUT_WIDTH-1:0] bmac_out,
   output logic                    out_valid
);

   localparam int LANES  = IN_WIDTH / 4;
   localparam int PROD_W = LUT_WIDTH + 1;
   localparam int LEVELS = (LANES > 1) ? $clog2(LANES) : 0;
   localparam int TREE_N = 1 << LEVELS;

   // Product table, entry {a, b} holds a*b as an 8-bit pattern. The only value above +63 is
   // (-8)(-8) = +64, stored as 8'h40, so the data field still sign-extends correctly.
   function automatic logic [256*LUT_WIDTH-1:0] buildLut();
      logic [256*LUT_WIDTH-1:0] tbl;
      int aVal;
      int bVal;
      tbl = '0;
      for (int idx = 0; idx < 256; idx++) begin
         aVal = (idx >> 4) & 15;
         bVal = idx & 15;
         if (aVal > 7) aVal = aVal - 16;
         if (bVal > 7) bVal = bVal - 16;
         tbl[idx*LUT_WIDTH +: LUT_WIDTH] = LUT_WIDTH'(aVal * bVal);
      end
      return tbl;
   endfunction

   localparam logic [256*LUT_WIDTH-1:0] PROD_LUT = buildLut();

   logic [PROD_W-1:0]              prod_d [LANES];
   logic [PROD_W-1:0]              prod_q [LANES];
   logic                           valid1_q;
   logic signed [OUTPUT_WIDTH-1:0] tree [2*TREE_N];
   logic signed [OUTPUT_WIDTH-1:0] dot;
   logic [OUTPUT_WIDTH-1:0]        out_d;
   logic [OUTPUT_WIDTH-1:0]        out_q;
   logic                           outValid_q;

   // Look up every lane product and widen it to a 9-bit signed value.
   always_comb begin
      logic [7:0]           lutIdx;
      logic [LUT_WIDTH-1:0] lutData;
      lutIdx  = '0;
      lutData = '0;
      for (int k = 0; k < LANES; k++) begin
         lutIdx    = {bmac_in_0[4*k +: 4], bmac_in_1[4*k +: 4]};
         lutData   = PROD_LUT[int'(lutIdx)*LUT_WIDTH +: LUT_WIDTH];
         prod_d[k] = {lutData[LUT_WIDTH-1], lutData};
      end
   end

   // Stage 1: capture the lane products of each valid operand pair and the valid bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid1_q <= 1'b0;
         for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
      end else begin
         valid1_q <= in_valid;
         if (in_valid) begin
            for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
         end
      end
   end

   // Balanced adder tree: leaves sit at TREE_N.., unused leaves stay zero, root is node 1.
   always_comb begin
      for (int i = 0; i < 2*TREE_N; i++) tree[i] = '0;
      for (int k = 0; k < LANES; k++) begin
         tree[TREE_N+k] = {{(OUTPUT_WIDTH-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]};
      end
      for (int i = TREE_N-1; i >= 1; i--) begin
         tree[i] = tree[2*i] + tree[2*i+1];
      end
      dot = tree[1];
   end

`ifdef BMAC_ACCUM_EN
   logic clr1_q;

   // Stage 1 side-band: the clear travels with its operands so it acts at stage 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) clr1_q <= 1'b0;
      else        clr1_q <= acc_clr;
   end

   // Accumulate (or reload on clear) with saturation to the signed output range.
   always_comb begin
      logic signed [OUTPUT_WIDTH:0] sumWide;
      logic signed [OUTPUT_WIDTH:0] baseWide;
      baseWide = clr1_q ? '0 : {out_q[OUTPUT_WIDTH-1], out_q};
      sumWide  = baseWide + {dot[OUTPUT_WIDTH-1], dot};
      out_d    = out_q;
      if (valid1_q) begin
         if (sumWide[OUTPUT_WIDTH] != sumWide[OUTPUT_WIDTH-1]) begin
            out_d = sumWide[OUTPUT_WIDTH] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                          : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
         end else begin
            out_d = sumWide[OUTPUT_WIDTH-1:0];
         end
      end else if (clr1_q) begin
         out_d = '0;
      end
   end
`else
   logic unusedAccClr;
   assign unusedAccClr = acc_clr;

   // Plain dot product: load each valid result, hold the last one through bubbles.
   always_comb begin
      out_d = out_q;
      if (valid1_q) out_d = dot;
   end
`endif

   // Stage 2: result register and output valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= '0;
         outValid_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         outValid_q <= valid1_q;
      end
   end

   assign bmac_out  = out_q;
   assign out_valid = outValid_q;

endmodule

// File: tb/tb_bmac.sv
// Self-checking bench for bmac: directed vectors plus random traffic against a
// lane-arithmetic reference model. Works with or without BMAC_ACCUM_EN.
module tb_bmac;

   typedef struct {
      logic        v;
      logic        c;
      logic [31:0] a;
      logic [31:0] b;
   } txn_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        inValid;
   logic        accClr;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [15:0] bmacOut;
   logic        outValid;

   int compared   = 0;
   int mismatched = 0;

   txn_t        pipeQ[$];
   int          modelAcc;
   logic [15:0] expOut;
   logic        expValid;

   bmac dut (
      .clk       (clk),
      .rst_n     (rstN),
      .in_valid  (inValid),
      .acc_clr   (accClr),
      .bmac_in_0 (opA),
      .bmac_in_1 (opB),
      .bmac_out  (bmacOut),
      .out_valid (outValid)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count one comparison and report it if it disagrees.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference dot product straight from the lane arithmetic.
   function automatic int dotRef(input logic [31:0] a, input logic [31:0] b);
      int s;
      int x;
      int y;
      s = 0;
      for (int k = 0; k < 8; k++) begin
         x = int'(a[4*k +: 4]);
         y = int'(b[4*k +: 4]);
         if (x > 7) x = x - 16;
         if (y > 7) y = y - 16;
         s = s + x * y;
      end
      return s;
   endfunction

   task automatic modelReset();
      txn_t bubble;
      bubble.v = 1'b0; bubble.c = 1'b0; bubble.a = '0; bubble.b = '0;
      pipeQ.delete();
      pipeQ.push_back(bubble);
      modelAcc = 0;
      expOut   = '0;
      expValid = 1'b0;
   endtask

   // Advance the model by one clock: the transaction driven the cycle before retires now.
   task automatic modelStep(input txn_t t);
      txn_t m;
      pipeQ.push_back(t);
      m = pipeQ.pop_front();
      expValid = m.v;
`ifdef BMAC_ACCUM_EN
      if (m.v) begin
         modelAcc = (m.c ? 0 : modelAcc) + dotRef(m.a, m.b);
         if (modelAcc > 32767)  modelAcc = 32767;
         if (modelAcc < -32768) modelAcc = -32768;
         expOut = 16'(modelAcc);
      end else if (m.c) begin
         modelAcc = 0;
         expOut   = '0;
      end
`else
      if (m.v) expOut = 16'(dotRef(m.a, m.b));
`endif
   endtask

   // Drive one cycle of inputs, step the model at the edge, then compare just after it.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic v, input logic c);
      txn_t t;
      @(negedge clk);
      opA = a; opB = b; inValid = v; accClr = c;
      t.v = v; t.c = c; t.a = a; t.b = b;
      @(posedge clk);
      modelStep(t);
      #1;
      checkOutput("out_valid", {31'b0, outValid}, {31'b0, expValid});
      checkOutput("bmac_out", {16'b0, bmacOut}, {16'b0, expOut});
   endtask

   logic [31:0] vecA [5];
   logic [31:0] vecB [5];
   logic [15:0] vecExp [5];
   logic [15:0] obs [5];
   logic [15:0] satExp;

   initial begin
      vecA = '{32'hDDDDDDDD, 32'h22222222, 32'h88888888, 32'h77777777, 32'h00000000};
      vecB = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h88888888, 32'h88888888, 32'h00000000};
`ifdef BMAC_ACCUM_EN
      vecExp = '{16'h0018, 16'h0008, 16'h0208, 16'h0048, 16'h0048};
      satExp = 16'h7FFF;
`else
      vecExp = '{16'h0018, 16'hFFF0, 16'h0200, 16'hFE40, 16'h0000};
      satExp = 16'h0200;
`endif
      rstN = 1'b1; inValid = 1'b0; accClr = 1'b0; opA = '0; opB = '0;
      #1 rstN = 1'b0;
      modelReset();
      #11;
      checkOutput("reset_out", {16'b0, bmacOut}, 32'h0);
      checkOutput("reset_valid", {31'b0, outValid}, 32'h0);
      @(negedge clk) rstN = 1'b1;

      // Directed vectors back to back, then a bubble.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecA[i], vecB[i], 1'b1, 1'b0);
         if (i > 0) obs[i-1] = bmacOut;
      end
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
      obs[4] = bmacOut;
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) checkOutput($sformatf("vector%0d", i), {16'b0, obs[i]}, {16'b0, vecExp[i]});

      // Back-to-back stream with a single bubble in the middle.
      applyStimulus($urandom, $urandom, 1'b1, 1'b0);
      applyStimulus($urandom, $urandom, 1'b1, 1'b0);
      applyStimulus($urandom, $urandom, 1'b0, 1'b0);
      applyStimulus($urandom, $urandom, 1'b1, 1'b0);
      applyStimulus($urandom, $urandom, 1'b1, 1'b0);
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);

      // Clear together with a new +24 vector reloads the running sum.
      applyStimulus(32'hDDDDDDDD, 32'hFFFFFFFF, 1'b1, 1'b1);
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("clr_load", {16'b0, bmacOut}, 32'h0018);
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b1);
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);

      // Repeated +512 vectors push the running sum into saturation.
      applyStimulus(32'h88888888, 32'h88888888, 1'b1, 1'b1);
      repeat (69) applyStimulus(32'h88888888, 32'h88888888, 1'b1, 1'b0);
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("saturate", {16'b0, bmacOut}, {16'b0, satExp});

      // Random traffic with bubbles, clears and extreme operands.
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         int          sel;
         sel = $urandom_range(0, 7);
         ra  = (sel == 0) ? 32'h88888888 : (sel == 1) ? 32'h77777777 : $urandom;
         rb  = (sel < 2)  ? 32'h88888888 : $urandom;
         applyStimulus(ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      end

      // Asynchronous reset with operands in flight.
      applyStimulus(32'h77777777, 32'h88888888, 1'b1, 1'b0);
      applyStimulus(32'h88888888, 32'h88888888, 1'b1, 1'b0);
      #2 rstN = 1'b0;
      modelReset();
      #1;
      checkOutput("async_rst_out", {16'b0, bmacOut}, 32'h0);
      checkOutput("async_rst_valid", {31'b0, outValid}, 32'h0);
      @(negedge clk);
      inValid = 1'b0; accClr = 1'b0;
      @(negedge clk) rstN = 1'b1;
      repeat (3) applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
      applyStimulus(32'hDDDDDDDD, 32'hFFFFFFFF, 1'b1, 1'b0);
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("first_after_rst", {16'b0, bmacOut}, 32'h0018);
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
